// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and FSM state type for the systolic array read-out path
package systolic_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int BANK_DEPTH = 8;
  localparam int BEAT_BYTES = 4;
  localparam int NUM_BEATS  = BANK_DEPTH / BEAT_BYTES;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/byte_bank_serializer.sv
// byte_bank_serializer: unloads an 8-byte vector onto a 32-bit bus as two tagged beats
module byte_bank_serializer #(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int BANK_DEPTH = systolic_pkg::BANK_DEPTH,
  parameter int BEAT_BYTES = systolic_pkg::BEAT_BYTES,
  localparam int NUM_BEATS = BANK_DEPTH / BEAT_BYTES,
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [BANK_DEPTH*DATA_WIDTH-1:0] load_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BEAT_BYTES*DATA_WIDTH-1:0] out_data,
  output logic [BW-1:0]                    out_beat,
  output logic                             out_last,
  output logic [15:0]                      vec_count
);
  import systolic_pkg::state_t;
  import systolic_pkg::IDLE;
  import systolic_pkg::SEND;
  localparam int BEAT_W = BEAT_BYTES * DATA_WIDTH;
  state_t                          state_q;
  logic [BW-1:0]                   idx_q;
  logic [BANK_DEPTH*DATA_WIDTH-1:0] vec_q;
  logic [15:0]                     cnt_q;
  logic                            send, last, load_fire, out_fire;
  always_comb begin
    send       = state_q == SEND;
    last       = idx_q == BW'(NUM_BEATS - 1);
    out_valid  = send;
    out_last   = send && last;
    out_beat   = idx_q;
    out_data   = vec_q[idx_q*BEAT_W +: BEAT_W];
    // last-beat acceptance frees the register in the same cycle, so no bubble between vectors
    load_ready = !reset && (send ? (last && out_ready) : 1'b1);
    load_fire  = load_valid && load_ready;
    out_fire   = send && out_ready;
    vec_count  = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (out_fire) begin
        idx_q   <= last ? '0 : idx_q + 1'b1;
        state_q <= last ? IDLE : SEND;
        if (last) cnt_q <= cnt_q + 16'd1;
      end
      if (load_fire) begin
        vec_q   <= load_data;
        idx_q   <= '0;
        state_q <= SEND;
      end
    end
  end
endmodule
